// File: rtl/sampler_dma_axi_rd_master.sv
// Voice DMA read responder: turns (address, beat count) requests into AXI4 INCR
// read bursts, splitting at 4 KB boundaries, and streams the data back with a 1-cycle delay.
module sampler_dma_axi_rd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ID_WIDTH   = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          dma_req,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] address,
    input  logic [7:0]                    dma_req_len,
    output logic                          dma_busy,
    output logic [C_M_AXI_DATA_WIDTH-1:0] dma_input_data,
    output logic                          dma_input_data_valid,
    output logic                          dma_input_data_last,
    output logic                          dma_req_dropped,
    output logic                          dma_resp_error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [3:0]                    m_axi_arcache,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [7:0]      rem_q;
    logic [7:0]      burst_q;
    logic [12:0]     bytes_to_4k;
    logic [10:0]     beats_to_4k;
    logic [7:0]      cur;
    logic            accept;
    logic            beat;
    logic            final_beat;
    logic            unused_bits;

    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = '0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = cur - 8'd1;

    // Beats left before the next 4 KB page; only exceeds 255 when rem_q is the limit.
    assign bytes_to_4k = 13'h1000 - {1'b0, addr_q[11:0]};
    assign beats_to_4k = bytes_to_4k[12:2];
    assign cur         = ({3'b000, rem_q} <= beats_to_4k) ? rem_q : beats_to_4k[7:0];

    assign accept      = (state_q == IDLE) && dma_req && (dma_req_len != 8'd0);
    assign beat        = m_axi_rvalid && m_axi_rready;
    assign final_beat  = beat && (rem_q == 8'd1);
    assign unused_bits = ^{address[1:0], bytes_to_4k[1:0], m_axi_rresp[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = AR;
            AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = R;
            end
            R: begin
                m_axi_rready = 1'b1;
                if (final_beat)                 state_d = IDLE;
                else if (beat && m_axi_rlast)   state_d = AR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q               <= '0;
            rem_q                <= '0;
            burst_q              <= '0;
            dma_busy             <= 1'b0;
            dma_input_data       <= '0;
            dma_input_data_valid <= 1'b0;
            dma_input_data_last  <= 1'b0;
            dma_req_dropped      <= 1'b0;
            dma_resp_error       <= 1'b0;
        end else begin
            dma_req_dropped      <= dma_req && (state_q != IDLE);
            dma_input_data_valid <= beat;
            dma_input_data_last  <= final_beat;
            if (beat) dma_input_data <= m_axi_rdata;

            if (accept) begin
                addr_q         <= {address[AW-1:2], 2'b00};
                rem_q          <= dma_req_len;
                dma_resp_error <= 1'b0;
                dma_busy       <= 1'b1;
            end

            if (state_q == AR && m_axi_arready) burst_q <= cur;

            if (beat) begin
                rem_q <= rem_q - 8'd1;
                if (m_axi_rresp[1]) dma_resp_error <= 1'b1;
                if (m_axi_rlast)    addr_q <= addr_q + AW'({burst_q, 2'b00});
            end

            if (final_beat) dma_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sampler_dma_axi_rd_master.sv
// Randomized bench for sampler_dma_axi_rd_master: an AXI read slave model drives the DUT
// and a request-level reference model predicts bursts, beats, busy, drop and error flags.
module tb_sampler_dma_axi_rd_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dma_req = 1'b0;
    logic [31:0] address = '0;
    logic [7:0]  dma_req_len = '0;
    logic        dma_busy;
    logic [31:0] dma_input_data;
    logic        dma_input_data_valid;
    logic        dma_input_data_last;
    logic        dma_req_dropped;
    logic        dma_resp_error;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [0:0]  m_axi_arid;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    always #5 clk = ~clk;

    sampler_dma_axi_rd_master #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ID_WIDTH(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dma_req(dma_req), .address(address),
        .dma_req_len(dma_req_len), .dma_busy(dma_busy), .dma_input_data(dma_input_data),
        .dma_input_data_valid(dma_input_data_valid), .dma_input_data_last(dma_input_data_last),
        .dma_req_dropped(dma_req_dropped), .dma_resp_error(dma_resp_error),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;

    int n_checks = 0;
    int n_fail = 0;

    ar_t         exp_ar[$];
    int          slv_len[$];
    int          slv_sent = 0;
    bit          exp_busy = 0, exp_err = 0, exp_drop = 0, exp_valid = 0, exp_last = 0;
    logic [31:0] exp_data = '0;
    int          rem_m = 0;
    bit          prev_wait = 0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;
    int          ar_stall_left = 0;
    int          r_mode = 0;
    int          err_beat = -1;
    bit          rresp_rand = 0;
    int          beat_no = 0;
    bit          tog = 0;
    int          ar_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected AR sequence for a request, from page arithmetic.
    task automatic push_split(input logic [31:0] a_in, input int len);
        logic [31:0] a;
        int r;
        a = a_in & 32'hFFFF_FFFC;
        r = len;
        while (r > 0) begin
            int room;
            int c;
            ar_t e;
            room = (4096 - int'(a[11:0])) / 4;
            c = (r < room) ? r : room;
            e.addr = a;
            e.len = 8'(c - 1);
            exp_ar.push_back(e);
            a = a + 32'(c * 4);
            r = r - c;
        end
    endtask

    function automatic bit r_go();
        if (r_mode == 0) return 1'b1;
        if (r_mode == 1) begin
            tog = ~tog;
            return tog;
        end
        return 1'($urandom_range(0, 1));
    endfunction

    // Called at a negedge: check outputs, drive slave inputs, advance the model across the next posedge.
    task automatic step();
        check("busy", 32'(dma_busy), 32'(exp_busy));
        check("resp_error", 32'(dma_resp_error), 32'(exp_err));
        check("dropped", 32'(dma_req_dropped), 32'(exp_drop));
        check("valid", 32'(dma_input_data_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("data", dma_input_data, exp_data);
            check("last", 32'(dma_input_data_last), 32'(exp_last));
        end else begin
            check("last_idle", 32'(dma_input_data_last), 32'd0);
        end
        if (prev_wait) begin
            check("arvalid_hold", 32'(m_axi_arvalid), 32'd1);
            check("araddr_stable", m_axi_araddr, prev_addr);
            check("arlen_stable", 32'(m_axi_arlen), 32'(prev_len));
        end

        if (m_axi_arvalid && ar_stall_left > 0) begin
            m_axi_arready = 1'b0;
            ar_stall_left--;
        end else begin
            m_axi_arready = ($urandom_range(0, 3) != 0);
        end
        if (!(m_axi_rvalid && !m_axi_rready)) begin
            if (slv_len.size() > 0 && r_go()) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = $urandom;
                m_axi_rlast  = (slv_sent + 1 == slv_len[0]);
                if (beat_no == err_beat)                       m_axi_rresp = 2'b10;
                else if (rresp_rand && $urandom_range(0, 7) == 0) m_axi_rresp = 2'($urandom_range(1, 3));
                else                                           m_axi_rresp = 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
            end
        end

        exp_drop  = dma_req && exp_busy;
        exp_valid = 0;
        if (dma_req && !exp_busy && dma_req_len != 0) begin
            exp_busy = 1;
            exp_err  = 0;
            rem_m    = int'(dma_req_len);
            beat_no  = 0;
            push_split(address, int'(dma_req_len));
        end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_count++;
            if (exp_ar.size() == 0) begin
                check("ar_spurious", 32'(m_axi_arvalid), 32'd0);
            end else begin
                ar_t e;
                e = exp_ar.pop_front();
                check("araddr", m_axi_araddr, e.addr);
                check("arlen", 32'(m_axi_arlen), 32'(e.len));
                slv_len.push_back(int'(m_axi_arlen) + 1);
            end
        end
        if (m_axi_rvalid && m_axi_rready) begin
            exp_valid = 1;
            exp_data  = m_axi_rdata;
            exp_last  = (rem_m == 1);
            if (m_axi_rresp[1]) exp_err = 1;
            rem_m--;
            if (rem_m == 0) exp_busy = 0;
            beat_no++;
            slv_sent++;
            if (m_axi_rlast) begin
                void'(slv_len.pop_front());
                slv_sent = 0;
            end
        end
        prev_wait = m_axi_arvalid && !m_axi_arready;
        prev_addr = m_axi_araddr;
        prev_len  = m_axi_arlen;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic request(input logic [31:0] a, input int len);
        dma_req     = 1'b1;
        address     = a;
        dma_req_len = 8'(len);
        step();
        dma_req     = 1'b0;
        address     = $urandom;
        dma_req_len = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget, input bit inject);
        int n;
        n = 0;
        while (exp_busy && n < budget) begin
            if (inject && $urandom_range(0, 15) == 0) begin
                dma_req     = 1'b1;
                dma_req_len = 8'($urandom);
            end
            step();
            dma_req = 1'b0;
            n++;
        end
        if (exp_busy) check("timeout_busy", 32'(exp_busy), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(dma_busy), 32'd0);
        check({tag, "_valid"}, 32'(dma_input_data_valid), 32'd0);
        check({tag, "_last"}, 32'(dma_input_data_last), 32'd0);
        check({tag, "_dropped"}, 32'(dma_req_dropped), 32'd0);
        check({tag, "_err"}, 32'(dma_resp_error), 32'd0);
        check({tag, "_arvalid"}, 32'(m_axi_arvalid), 32'd0);
        check({tag, "_rready"}, 32'(m_axi_rready), 32'd0);
        check({tag, "_data"}, dma_input_data, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        check("araddr_reset", m_axi_araddr, 32'd0);
        check("arsize", 32'(m_axi_arsize), 32'd2);
        check("arburst", 32'(m_axi_arburst), 32'd1);
        check("arid", 32'(m_axi_arid), 32'd0);
        check("arcache", 32'(m_axi_arcache), 32'd3);
        check("arprot", 32'(m_axi_arprot), 32'd0);
        reset_n = 1'b1;
        step();

        // Basic burst
        c0 = ar_count;
        request(32'h1000_0000, 4);
        wait_idle(200, 0);
        check("ar_count_basic", 32'(ar_count - c0), 32'd1);

        // 4 KB split, back-to-back with the previous request's busy fall
        c0 = ar_count;
        request(32'h2000_0FF0, 64);
        wait_idle(1000, 0);
        check("ar_count_split", 32'(ar_count - c0), 32'd2);

        // Stalled AR and toggling R
        ar_stall_left = 10;
        r_mode = 1;
        c0 = ar_count;
        request(32'h3000_0100, 16);
        wait_idle(1000, 0);
        check("ar_count_stall", 32'(ar_count - c0), 32'd1);
        r_mode = 0;

        // Drop while busy, then zero-length request
        c0 = ar_count;
        request(32'h4000_0000, 8);
        dma_req = 1'b1; dma_req_len = 8'd5; address = 32'h4444_0000;
        step();
        dma_req = 1'b0;
        wait_idle(500, 0);
        check("ar_count_drop", 32'(ar_count - c0), 32'd1);
        repeat (2) step();
        c0 = ar_count;
        request(32'h5000_0000, 0);
        repeat (5) step();
        check("ar_count_zero", 32'(ar_count - c0), 32'd0);

        // Error response on beat 2, cleared by next accepted request
        err_beat = 1;
        request(32'h6000_0000, 4);
        wait_idle(200, 0);
        err_beat = -1;
        check("err_sticky", 32'(dma_resp_error), 32'd1);
        request(32'h6000_0100, 3);
        wait_idle(200, 0);

        // Page-edge cases: exact end, one-beat halves, max length, ignored low bits
        c0 = ar_count;
        request(32'h7000_0FC0, 16);
        wait_idle(500, 0);
        check("ar_count_exact4k", 32'(ar_count - c0), 32'd1);
        request(32'h7000_0FFC, 2);
        wait_idle(200, 0);
        request(32'h8000_0000, 255);
        wait_idle(2000, 0);
        request(32'h9000_0FF3, 4);
        wait_idle(200, 0);

        // Reset in the middle of an 8-beat read
        request(32'hA000_0000, 8);
        n = 0;
        while (rem_m != 7 && n < 200) begin
            step();
            n++;
        end
        check("reset_reached_beat1", 32'(rem_m), 32'd7);
        #2 reset_n = 1'b0;
        #1 check_cleared("midreset");
        @(negedge clk);
        exp_ar.delete();
        slv_len.delete();
        slv_sent = 0; rem_m = 0; beat_no = 0;
        exp_busy = 0; exp_err = 0; exp_drop = 0; exp_valid = 0; exp_last = 0;
        prev_wait = 0;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_arready = 1'b0;
        reset_n = 1'b1;
        step();
        c0 = ar_count;
        request(32'hA000_0040, 2);
        wait_idle(200, 0);
        check("ar_count_postreset", 32'(ar_count - c0), 32'd1);

        // Randomized requests near page edges with stalls, errors and drop attempts
        rresp_rand = 1;
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            r_mode = $urandom_range(0, 2);
            ar_stall_left = $urandom_range(0, 4);
            a = 32'hB000_0000 + 32'(i << 12) + 32'($urandom_range(3072, 4095));
            request(a, $urandom_range(0, 255));
            wait_idle(2000, 1);
            if ($urandom_range(0, 1) == 1) step();
        end
        rresp_rand = 0;
        repeat (3) step();
        check("ar_leftover", 32'(exp_ar.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
